rv_decode_stage: RTL
====================

Name: rv_decode_stage

Overview:
- Registered, parametrised RISC-V decode stage. Sits between instruction fetch and register-file read/execute.
- Accepts one instruction word per valid/ready handshake and produces decoded fields one cycle later.
- Compared with the combinational field extractor it supersedes, it adds:
  - XLEN-wide, correctly formatted immediates for all base formats, including JALR and SYSTEM.
  - Defined zero values for unused fields.
  - An illegal-instruction flag.
  - Back-pressure through a 1-entry skid buffer.
  - Pipeline flush.
  - A retired-decode counter.

Parameters:
- XLEN, 32, immediate/PC datapath width; legal values 32 or 64.
- PC_EN, 1, when 1 the instruction PC is carried alongside the decoded fields; when 0, out_pc is tied to 0.
- CNT_W, 32, width of the decoded-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discards all held instructions.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept an instruction.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts the bundle.
- out_opcode  out  7  instr[6:0].
- out_rd, out_rs1, out_rs2  out  5 each  register indices; 0 when unused by the format.
- out_func  out  4  {funct3, instr[30]}; 0 for U/J formats.
- out_imm  out  XLEN  sign-extended immediate.
- out_fmt  out  3  format code: R, I, S, B, U, J, NONE.
- out_illegal  out  1  unsupported opcode, or instr[1:0] != 2'b11.
- out_pc  out  XLEN  PC of the decoded instruction.
- decode_count  out  CNT_W  number of bundles accepted downstream.

Behaviour:
- Reset (asynchronous, active-high):
  - out_valid=0, skid_valid=0, decode_count=0.
  - All out_* data fields = 0.
  - in_ready=1 the first cycle after reset deasserts.
- Latency: 1 cycle from an accepted input (in_valid & in_ready) to out_valid, when the output register is empty or draining.
- in_ready = !skid_valid, driven directly from a register (no combinational path from out_ready).
- Input acceptance:
  - Output register empty or draining (out_ready=1): the decoded input loads the output register.
  - Output register stalled (out_valid & !out_ready): the decoded input loads the skid register, and skid_valid is set.
- On an output handshake while skid_valid=1: the skid contents move to the output register next cycle and skid_valid clears. A new input is not accepted in that cycle, because in_ready=0.
- No bubble while the skid is empty: back-to-back handshakes sustain 1 instruction/cycle.
- Output stability: while out_valid & !out_ready, every out_* field holds stable.
- Flush:
  - Next cycle, out_valid=0 and skid_valid=0.
  - An input presented in the flush cycle is dropped.
  - decode_count is not incremented by a handshake in that same cycle.
- Opcode decode (instr[6:0]) and immediate construction:
  - 0110011 R: imm=0.
  - 0000011 / 0010011 / 1100111 (JALR) I: imm=sext(instr[31:20]); rs2=0.
  - 1110011 SYSTEM: I format with the same immediate.
  - 0100011 S: imm=sext({instr[31:25], instr[11:7]}); rd=0.
  - 1100011 B: imm=sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}); rd=0.
  - 0110111 / 0010111 U: imm=sext({instr[31:12], 12'b0}); rs1=rs2=0; func=0.
  - 1101111 J: imm=sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}); rs1=rs2=0; func=0.
  - 0001111 FENCE: fmt=NONE, all fields 0.
  - Any other opcode, or instr[1:0] != 2'b11: out_illegal=1, fmt=NONE, all fields 0.
- Illegal instructions still flow through the handshake. They are never dropped.
- Sign extension is always to XLEN.
- decode_count increments by 1 on each out_valid & out_ready and wraps modulo 2^CNT_W.

Decomposition:
- Shared package rv_pkg holds:
  - opcode localparams (OP_R, OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_FENCE, OP_SYSTEM);
  - format encodings FMT_R..FMT_NONE;
  - a decoded-bundle struct.
- Sub-module rv_decode_comb: purely combinational instruction-to-bundle decoder. It is instantiated once on the input path, so both the output register and the skid register store already-decoded bundles.

Test Plan:
- addi x1,x2,-1 (0xFFF10093), out_ready=1 → 1 cycle later: out_valid=1, rd=1, rs1=2, rs2=0, imm=all ones, func=4'b0001, fmt=I, illegal=0.
- lui x5,0x12345 (0x123452B7) → imm=0x12345000 (XLEN=32) / 0x0000000012345000 (XLEN=64), rs1=rs2=0, func=0.
- jal x1,+8 (0x008000EF) → imm=8, rd=1, fmt=J; beq x0,x0,-4 (0xFE000EE3) → imm=-4, rd=0, fmt=B.
- Stream of 4 instructions with out_ready held 0 for 3 cycles:
  - in_ready drops after the 2nd is accepted;
  - no loss, no duplication, order preserved;
  - decode_count=4 after draining.
- flush asserted with both registers full → next cycle out_valid=0 and in_ready=1; decode_count unchanged. 0x00000000 input → out_illegal=1, out_valid=1.
- rst asserted mid-stream between clock edges → out_valid and decode_count clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RISC-V decode definitions: opcodes, format codes and the decoded bundle.
package rv_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      FMT_R    = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_NONE = 3'd6
   } fmt_e;

   // Every base-format immediate fits in 32 bits once sign-extended; the
   // stage widens it to XLEN at its output, so the bundle stays XLEN-agnostic.
   typedef struct packed {
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [3:0]  func;
      logic [31:0] imm;
      fmt_e        fmt;
      logic        illegal;
   } dec_t;

endpackage

// File: rtl/rv_decode_comb.sv
// Combinational instruction-word to decoded-bundle translation.
module rv_decode_comb
   import rv_pkg::*;
(
   input  logic [31:0] instr,
   output dec_t        dec
);

   // Field extraction and immediate assembly; unused fields stay zero
   always_comb begin
      dec        = '0;
      dec.fmt    = FMT_NONE;
      dec.opcode = instr[6:0];
      if (instr[1:0] != 2'b11) begin
         dec.illegal = 1'b1;
      end else begin
         case (instr[6:0])
            OP_R: begin
               dec.fmt  = FMT_R;
               dec.rd   = instr[11:7];
               dec.rs1  = instr[19:15];
               dec.rs2  = instr[24:20];
               dec.func = {instr[14:12], instr[30]};
            end
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
               dec.fmt  = FMT_I;
               dec.rd   = instr[11:7];
               dec.rs1  = instr[19:15];
               dec.func = {instr[14:12], instr[30]};
               dec.imm  = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
               dec.fmt  = FMT_S;
               dec.rs1  = instr[19:15];
               dec.rs2  = instr[24:20];
               dec.func = {instr[14:12], instr[30]};
               dec.imm  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
               dec.fmt  = FMT_B;
               dec.rs1  = instr[19:15];
               dec.rs2  = instr[24:20];
               dec.func = {instr[14:12], instr[30]};
               dec.imm  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
               dec.fmt = FMT_U;
               dec.rd  = instr[11:7];
               dec.imm = {instr[31:12], 12'b0};
            end
            OP_JAL: begin
               dec.fmt = FMT_J;
               dec.rd  = instr[11:7];
               dec.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OP_FENCE: begin
               dec.fmt = FMT_NONE;
            end
            default: begin
               dec.illegal = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered decode stage with a one-entry skid buffer, flush and a
// counter of bundles handed downstream.
module rv_decode_stage
   import rv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int PC_EN = 1,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [XLEN-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [6:0]       out_opcode,
   output logic [4:0]       out_rd,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [3:0]       out_func,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic             out_illegal,
   output logic [XLEN-1:0]  out_pc,
   output logic [CNT_W-1:0] decode_count
);

   dec_t            in_dec;
   dec_t            out_reg;
   dec_t            skid_reg;
   logic [XLEN-1:0] out_pc_reg;
   logic [XLEN-1:0] skid_pc_reg;
   logic            out_valid_reg;
   logic            skid_valid_reg;
   logic [CNT_W-1:0] count_reg;

   // Decoding happens before storage, so both holding registers keep bundles
   rv_decode_comb u_decode (
      .instr (in_instr),
      .dec   (in_dec)
   );

   // Output register and skid buffer: load, stall into skid, drain skid, flush
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_reg  <= 1'b0;
         out_reg        <= '0;
         out_pc_reg     <= '0;
         skid_valid_reg <= 1'b0;
         skid_reg       <= '0;
         skid_pc_reg    <= '0;
      end else if (flush) begin
         out_valid_reg  <= 1'b0;
         skid_valid_reg <= 1'b0;
      end else if (skid_valid_reg) begin
         // in_ready is low here, so only the skid can move forward
         if (out_ready) begin
            out_reg        <= skid_reg;
            out_pc_reg     <= skid_pc_reg;
            skid_valid_reg <= 1'b0;
         end
      end else if (!out_valid_reg || out_ready) begin
         out_valid_reg <= in_valid;
         if (in_valid) begin
            out_reg    <= in_dec;
            out_pc_reg <= in_pc;
         end
      end else if (in_valid) begin
         skid_reg       <= in_dec;
         skid_pc_reg    <= in_pc;
         skid_valid_reg <= 1'b1;
      end
   end

   // Count bundles taken downstream; a flush cycle's handshake does not count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else if (out_valid_reg && out_ready && !flush) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign in_ready     = !skid_valid_reg;
   assign out_valid    = out_valid_reg;
   assign out_opcode   = out_reg.opcode;
   assign out_rd       = out_reg.rd;
   assign out_rs1      = out_reg.rs1;
   assign out_rs2      = out_reg.rs2;
   assign out_func     = out_reg.func;
   assign out_imm      = XLEN'($signed(out_reg.imm));
   assign out_fmt      = out_reg.fmt;
   assign out_illegal  = out_reg.illegal;
   assign out_pc       = (PC_EN != 0) ? out_pc_reg : '0;
   assign decode_count = count_reg;

endmodule
